// File: rtl/roe_ctrl_seq.sv
// roe_ctrl_seq: registered decode/sequencing control for the R.O.E core.
// Optional feature macro ROE_CTRL_PERF_EN adds retired/stall performance counters.
module roe_ctrl_seq #(
  parameter int INSTR_W = 9,
  parameter int SET_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               mem_ack,
  output logic               ctrl_valid,
  output logic [SET_W-1:0]   set_read0,
  output logic [SET_W-1:0]   set_read1,
  output logic [SET_W-1:0]   set_write,
  output logic               reg_imm,
  output logic               reg_write_src,
  output logic               mem_write,
  output logic               mem_read,
  output logic               reg_write,
  output logic               reg_read_write,
  output logic               reg_write_read,
  output logic               branch,
  output logic [3:0]         alu_op,
  output logic [1:0]         alu_src,
  output logic [1:0]         state_dbg
`ifdef ROE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_retired,
  output logic [CNT_W-1:0]   perf_stall
`endif
);

  // Handshake: an instruction is taken on a rising edge where instr_valid and
  // instr_ready are both 1; the source must hold instr stable until then.
  // ctrl_valid qualifies every registered control output for that cycle.

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_imm;
    logic       reg_write_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       reg_read_write;
    logic       reg_write_read;
    logic       branch;
    logic [3:0] alu_op;
    logic [1:0] alu_src;
  } ctrl_t;

  localparam logic [2:0] OP_REG   = 3'd0;
  localparam logic [2:0] OP_ARITH = 3'd1;
  localparam logic [2:0] OP_SHIFT = 3'd2;
  localparam logic [2:0] OP_HARD  = 3'd3;
  localparam logic [2:0] OP_SLT   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_AND   = 3'd6;
  localparam logic [2:0] OP_OR    = 3'd7;

  localparam logic [1:0] F2_REDEF  = 2'd0;
  localparam logic [1:0] F2_LW     = 2'd1;
  localparam logic [1:0] F2_SW     = 2'd2;
  localparam logic [1:0] F2_BRANCH = 2'd3;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SHIFTL = 4'd2;
  localparam logic [3:0] ALU_SHIFTR = 4'd3;
  localparam logic [3:0] ALU_SLB    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_XOR    = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, dec;
  logic   ctrl_valid_q, ctrl_valid_d;
  logic   dec_mem, dec_branch, dec_redef;
  logic   accept;
  logic [SET_W-1:0] set_read0_d, set_read1_d, set_write_d;

  logic [2:0] opcode;
  logic [1:0] fun2;
  logic       fun1;
  logic       unused_instr;

  assign opcode = instr[INSTR_W-1 -: 3];
  assign fun2   = instr[INSTR_W-4 -: 2];
  assign fun1   = instr[INSTR_W-4];
  // Operand fields are consumed by the datapath, not here.
  assign unused_instr = ^instr;

  assign instr_ready = (state_q != ST_MEM_WAIT);
  assign accept      = instr_valid & instr_ready;

  // Pure decode of the presented instruction.
  always_comb begin
    dec        = '0;
    dec_mem    = 1'b0;
    dec_branch = 1'b0;
    dec_redef  = 1'b0;
    case (opcode)
      OP_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 2'b01;
        dec.alu_op    = ALU_SLB;
      end
      OP_ARITH, OP_SHIFT: begin
        dec.reg_imm        = 1'b1;
        dec.reg_read_write = 1'b1;
        dec.reg_write_read = 1'b1;
        dec.reg_write      = 1'b1;
        if (opcode == OP_ARITH) dec.alu_op = fun1 ? ALU_SUB : ALU_ADD;
        else                    dec.alu_op = fun1 ? ALU_SHIFTR : ALU_SHIFTL;
      end
      OP_HARD: begin
        case (fun2)
          F2_REDEF: dec_redef = 1'b1;
          F2_LW: begin
            dec.mem_read      = 1'b1;
            dec.reg_write     = 1'b1;
            dec.reg_write_src = 1'b1;
            dec.alu_op        = ALU_ADD;
            dec.alu_src       = 2'b10;
            dec_mem           = 1'b1;
          end
          F2_SW: begin
            dec.mem_write = 1'b1;
            dec.alu_op    = ALU_ADD;
            dec.alu_src   = 2'b10;
            dec_mem       = 1'b1;
          end
          F2_BRANCH: begin
            dec.branch = 1'b1;
            dec.alu_op = ALU_SUB;
            dec_branch = 1'b1;
          end
          default: ;
        endcase
      end
      OP_SLT: begin dec.reg_write = 1'b1; dec.alu_op = ALU_SLT; end
      OP_XOR: begin dec.reg_write = 1'b1; dec.alu_op = ALU_XOR; end
      OP_AND: begin dec.reg_write = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.reg_write = 1'b1; dec.alu_op = ALU_OR;  end
      default: ;
    endcase
  end

  // Next state, next registered control and register-set pointers.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = ctrl_valid_q;
    set_read0_d  = set_read0;
    set_read1_d  = set_read1;
    set_write_d  = set_write;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          ctrl_d       = dec;
          ctrl_valid_d = 1'b1;
          if (dec_mem)         state_d = ST_MEM_WAIT;
          else if (dec_branch) state_d = ST_FLUSH;
          if (dec_redef) begin
            if (instr[SET_W]) begin
              set_write_d = instr[SET_W-1:0];
            end else begin
              set_read0_d = instr[SET_W-1:0];
              set_read1_d = instr[SET_W-1:0] + SET_W'(1);
            end
          end
        end else begin
          ctrl_d       = '0;
          ctrl_valid_d = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          ctrl_d       = '0;
          ctrl_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Whatever is accepted in this slot is dropped.
        ctrl_d       = '0;
        ctrl_valid_d = 1'b0;
        state_d      = ST_RUN;
      end
      default: begin
        ctrl_d       = '0;
        ctrl_valid_d = 1'b0;
        state_d      = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      set_read0    <= '0;
      set_read1    <= SET_W'(1);
      set_write    <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      set_read0    <= set_read0_d;
      set_read1    <= set_read1_d;
      set_write    <= set_write_d;
    end
  end

  assign ctrl_valid     = ctrl_valid_q;
  assign reg_imm        = ctrl_q.reg_imm;
  assign reg_write_src  = ctrl_q.reg_write_src;
  assign mem_write      = ctrl_q.mem_write;
  assign mem_read       = ctrl_q.mem_read;
  assign reg_write      = ctrl_q.reg_write;
  assign reg_read_write = ctrl_q.reg_read_write;
  assign reg_write_read = ctrl_q.reg_write_read;
  assign branch         = ctrl_q.branch;
  assign alu_op         = ctrl_q.alu_op;
  assign alu_src        = ctrl_q.alu_src;
  assign state_dbg      = state_q;

`ifdef ROE_CTRL_PERF_EN
  logic retire_now, stall_now;

  // An instruction completes in the last cycle its ctrl_valid is shown.
  assign retire_now = ctrl_valid_q & ((state_q != ST_MEM_WAIT) | mem_ack);
  assign stall_now  = (state_q == ST_MEM_WAIT) & ~mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (retire_now) perf_retired <= perf_retired + CNT_W'(1);
      if (stall_now)  perf_stall   <= perf_stall + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
